// File: rtl/bp_me_route_pkg.sv
// Shared types and field positions for the address-to-CCE router.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bp_me_route_pkg;

    typedef enum logic [1:0] {
        route_io_e     = 2'd0,
        route_local_e  = 2'd1,
        route_dram_e   = 2'd2,
        route_coproc_e = 2'd3
    } bp_me_route_class_e;

    typedef enum logic [1:0] {
        stripe_block_e = 2'd0,
        stripe_page_e  = 2'd1,
        stripe_hash_e  = 2'd2,
        stripe_fixed_e = 2'd3
    } bp_me_stripe_mode_e;

    // Fields of a local (below-DRAM) address.
    localparam int local_dev_lsb_gp   = 18;
    localparam int local_dev_width_gp = 4;
    localparam int local_cce_lsb_gp   = 22;
    localparam int local_cce_width_gp = 7;

endpackage

// File: rtl/bp_me_addr_route_classify.sv
// Combinational address classifier: paddr + stripe mode/fixed id -> {class, cce id, err}.
// Latency: zero (purely combinational).
// Backpressure: none; the caller latches the result on accept.
module bp_me_addr_route_classify
    import bp_me_route_pkg::*;
#(
    parameter int                       paddr_width_p  = 40,
    parameter int                       cce_id_width_p = 6,
    parameter int                       num_core_p     = 4,
    parameter int                       num_io_p       = 1,
    parameter int                       io_cce_base_p  = 4,
    parameter int                       did_width_p    = 3,
    parameter int                       block_offset_p = 6,
    parameter int                       page_offset_p  = 12,
    parameter logic [paddr_width_p-1:0] dram_base_p    = 40'h00_8000_0000,
    parameter logic [paddr_width_p-1:0] coproc_base_p  = 40'h10_0000_0000,
    parameter int                       host_dev_p     = 1
) (
    input  logic [paddr_width_p-1:0]  paddr,
    input  bp_me_stripe_mode_e        mode,
    input  logic [cce_id_width_p-1:0] fixed_id,
    output bp_me_route_class_e        route_class,
    output logic [cce_id_width_p-1:0] cce_id,
    output logic                      err
);

    localparam int lg_core_lp   = $clog2(num_core_p);
    localparam int hash_w_lp    = (lg_core_lp == 0) ? 1 : lg_core_lp;
    localparam int hash_bits_lp = paddr_width_p - did_width_p - block_offset_p;
    // Masks rather than L-bit slices so that L==0 (single core / single IO) collapses to 0.
    localparam logic [paddr_width_p-1:0] core_mask_lp = paddr_width_p'(num_core_p - 1);
    localparam logic [paddr_width_p-1:0] io_mask_lp   = paddr_width_p'((1 << $clog2(num_io_p)) - 1);

    // XOR-fold of the block-index bits into L-bit chunks; the partial top chunk is
    // implicitly zero-padded because its missing bits never toggle anything.
    function automatic logic [paddr_width_p-1:0] hash_f(input logic [paddr_width_p-1:0] a);
        logic [paddr_width_p-1:0] h;
        h = '0;
        for (int i = 0; i < hash_bits_lp; i++) begin
            h[i % hash_w_lp] = h[i % hash_w_lp] ^ a[block_offset_p + i];
        end
        return h & core_mask_lp;
    endfunction

    logic [did_width_p-1:0]        did;
    logic [local_dev_width_gp-1:0] dev;
    logic [local_cce_width_gp-1:0] cce_field;
    logic                          below_dram;
    logic                          below_coproc;
    logic                          is_io;
    logic [paddr_width_p-1:0]      io_sel;
    logic [paddr_width_p-1:0]      dram_id;

    assign did          = paddr[paddr_width_p-1 -: did_width_p];
    assign dev          = paddr[local_dev_lsb_gp +: local_dev_width_gp];
    assign cce_field    = paddr[local_cce_lsb_gp +: local_cce_width_gp];
    assign below_dram   = (paddr < dram_base_p);
    assign below_coproc = (paddr < coproc_base_p);
    assign is_io        = (did != '0)
                        | (below_dram & (dev == local_dev_width_gp'(host_dev_p)))
                        | (below_dram & (cce_field >= local_cce_width_gp'(num_core_p)));
    assign io_sel       = (paddr >> page_offset_p) & io_mask_lp;

    always_comb begin
        dram_id = '0;
        case (mode)
            stripe_block_e: dram_id = (paddr >> block_offset_p) & core_mask_lp;
            stripe_page_e:  dram_id = (paddr >> page_offset_p) & core_mask_lp;
            stripe_hash_e:  dram_id = hash_f(paddr);
            default:        dram_id = paddr_width_p'(fixed_id);
        endcase
    end

    always_comb begin
        route_class = route_coproc_e;
        cce_id      = '0;
        err         = 1'b0;
        if (is_io) begin
            route_class = route_io_e;
            cce_id      = cce_id_width_p'(io_cce_base_p) + io_sel[cce_id_width_p-1:0];
        end else if (below_dram) begin
            // cce_field < num_core_p here, so narrowing loses nothing.
            route_class = route_local_e;
            cce_id      = cce_id_width_p'(cce_field);
        end else if (below_coproc) begin
            route_class = route_dram_e;
            cce_id      = dram_id[cce_id_width_p-1:0];
        end else begin
            err         = 1'b1;
        end
    end

endmodule

// File: rtl/bp_me_fifo_2.sv
// Generic two-entry in-order FIFO primitive (clk_i, reset_i, v_i/data_i/ready_o in, v_o/data_o/yumi_i out).
// Latency: data written on one edge is visible on v_o/data_o after that edge.
// Backpressure: ready_o = not full; no ready-through, a dequeue while full frees space next cycle.
module bp_me_fifo_2 #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_r [2];
    logic               rd_ptr_r;
    logic               wr_ptr_r;
    logic [1:0]         count_r;
    logic               enq;
    logic               deq;

    assign ready_o = (count_r != 2'd2);
    assign v_o     = (count_r != 2'd0);
    assign data_o  = mem_r[rd_ptr_r];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (enq) begin
                mem_r[wr_ptr_r] <= data_i;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (deq) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, enq} - {1'b0, deq};
        end
    end

endmodule

// File: rtl/bp_me_addr_to_cce_id_router.sv
// Pipelined address-to-CCE router: classify paddr, latch {class,id,err} into a 2-entry FIFO.
// Latency: one cycle from accept to v_o. Optional per-class counters: BP_ME_ADDR_ROUTE_STATS_EN.
// Backpressure: ready_o = FIFO not full (no ready-through); outputs held until yumi_i.
// Ports: cfg_v_i/cfg_mode_i/cfg_fixed_id_i config write; v_i/paddr_i/ready_o request;
//        v_o/cce_id_o/class_o/err_o/yumi_i result; stats_o = {coproc,dram,local,io} counters.
module bp_me_addr_to_cce_id_router
    import bp_me_route_pkg::*;
#(
    parameter int                       paddr_width_p  = 40,
    parameter int                       cce_id_width_p = 6,
    parameter int                       num_core_p     = 4,
    parameter int                       num_io_p       = 1,
    parameter int                       io_cce_base_p  = 4,
    parameter int                       did_width_p    = 3,
    parameter int                       block_offset_p = 6,
    parameter int                       page_offset_p  = 12,
    parameter logic [paddr_width_p-1:0] dram_base_p    = 40'h00_8000_0000,
    parameter logic [paddr_width_p-1:0] coproc_base_p  = 40'h10_0000_0000,
    parameter int                       host_dev_p     = 1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      cfg_v_i,
    input  logic [1:0]                cfg_mode_i,
    input  logic [cce_id_width_p-1:0] cfg_fixed_id_i,
    input  logic [paddr_width_p-1:0]  paddr_i,
    input  logic                      v_i,
    output logic                      ready_o,
    output logic [cce_id_width_p-1:0] cce_id_o,
    output logic [1:0]                class_o,
    output logic                      err_o,
    output logic                      v_o,
    input  logic                      yumi_i,
    output logic [127:0]              stats_o
);

    localparam int entry_w_lp = 3 + cce_id_width_p;

    bp_me_stripe_mode_e        mode_r;
    logic [cce_id_width_p-1:0] fixed_id_r;
    bp_me_route_class_e        route_class;
    logic [cce_id_width_p-1:0] route_id;
    logic                      route_err;
    logic [entry_w_lp-1:0]     head;
    logic                      accept;

    assign accept = v_i & ready_o;

    // Requests accepted on the cfg_v_i cycle still see the old registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mode_r     <= stripe_block_e;
            fixed_id_r <= '0;
        end else if (cfg_v_i) begin
            mode_r     <= bp_me_stripe_mode_e'(cfg_mode_i);
            fixed_id_r <= cfg_fixed_id_i;
        end
    end

    bp_me_addr_route_classify #(
        .paddr_width_p (paddr_width_p),
        .cce_id_width_p(cce_id_width_p),
        .num_core_p    (num_core_p),
        .num_io_p      (num_io_p),
        .io_cce_base_p (io_cce_base_p),
        .did_width_p   (did_width_p),
        .block_offset_p(block_offset_p),
        .page_offset_p (page_offset_p),
        .dram_base_p   (dram_base_p),
        .coproc_base_p (coproc_base_p),
        .host_dev_p    (host_dev_p)
    ) classify (
        .paddr      (paddr_i),
        .mode       (mode_r),
        .fixed_id   (fixed_id_r),
        .route_class(route_class),
        .cce_id     (route_id),
        .err        (route_err)
    );

    bp_me_fifo_2 #(
        .width_p(entry_w_lp)
    ) out_fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .v_i    (v_i),
        .data_i ({route_class, route_err, route_id}),
        .ready_o(ready_o),
        .v_o    (v_o),
        .data_o (head),
        .yumi_i (yumi_i)
    );

    assign class_o  = head[entry_w_lp-1 -: 2];
    assign err_o    = head[cce_id_width_p];
    assign cce_id_o = head[cce_id_width_p-1:0];

`ifdef BP_ME_ADDR_ROUTE_STATS_EN
    logic [3:0][31:0] stat_cnt_r;

    // A config write clears the counters and takes precedence over a same-cycle accept.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stat_cnt_r <= '0;
        end else if (cfg_v_i) begin
            stat_cnt_r <= '0;
        end else if (accept) begin
            stat_cnt_r[route_class] <= stat_cnt_r[route_class] + 32'd1;
        end
    end

    assign stats_o = stat_cnt_r;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign stats_o       = '0;
`endif

endmodule

// File: tb/tb_bp_me_addr_to_cce_id_router.sv
module tb_bp_me_addr_to_cce_id_router;

    typedef struct packed {
        logic [1:0] cls;
        logic       err;
        logic [5:0] id;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         cfg_v_i;
    logic [1:0]   cfg_mode_i;
    logic [5:0]   cfg_fixed_id_i;
    logic [39:0]  paddr_i;
    logic         v_i;
    logic         ready_o;
    logic [5:0]   cce_id_o;
    logic [1:0]   class_o;
    logic         err_o;
    logic         v_o;
    logic         yumi_i;
    logic [127:0] stats_o;

    exp_t         sb[$];
    int           cnt[4];
    int           n_chk  = 0;
    int           n_fail = 0;

    always #5 clk_i = ~clk_i;

    bp_me_addr_to_cce_id_router dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .cfg_v_i       (cfg_v_i),
        .cfg_mode_i    (cfg_mode_i),
        .cfg_fixed_id_i(cfg_fixed_id_i),
        .paddr_i       (paddr_i),
        .v_i           (v_i),
        .ready_o       (ready_o),
        .cce_id_o      (cce_id_o),
        .class_o       (class_o),
        .err_o         (err_o),
        .v_o           (v_o),
        .yumi_i        (yumi_i),
        .stats_o       (stats_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
    endtask

    // Called at a negedge; presents one request that must be accepted at the next posedge.
    task automatic drive_req(input string tag, input logic [39:0] a,
                             input logic [1:0] c, input logic e, input logic [5:0] id);
        chk({tag, "_ready"}, 128'(ready_o), 128'(1));
        v_i     = 1'b1;
        paddr_i = a;
        sb.push_back('{cls: c, err: e, id: id});
        cnt[c]++;
        @(negedge clk_i);
        v_i = 1'b0;
    endtask

    // Called at a negedge; compares the head against the scoreboard and consumes it.
    task automatic pop_chk(input string tag);
        exp_t x;
        chk({tag, "_v"}, 128'(v_o), 128'(1));
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 128'(0), 128'(1));
        end else begin
            x = sb.pop_front();
            chk({tag, "_class"}, 128'(class_o), 128'(x.cls));
            chk({tag, "_err"}, 128'(err_o), 128'(x.err));
            chk({tag, "_id"}, 128'(cce_id_o), 128'(x.id));
        end
        yumi_i = 1'b1;
        @(negedge clk_i);
        yumi_i = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] m, input logic [5:0] f);
        cfg_v_i        = 1'b1;
        cfg_mode_i     = m;
        cfg_fixed_id_i = f;
        @(negedge clk_i);
        cfg_v_i = 1'b0;
        clear_model();
    endtask

    task automatic chk_stats(input string tag);
        logic [127:0] exp;
`ifdef BP_ME_ADDR_ROUTE_STATS_EN
        exp = {32'(cnt[3]), 32'(cnt[2]), 32'(cnt[1]), 32'(cnt[0])};
`else
        exp = '0;
`endif
        chk(tag, stats_o, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i        = 1'b1;
        cfg_v_i        = 1'b0;
        cfg_mode_i     = 2'd0;
        cfg_fixed_id_i = 6'd0;
        paddr_i        = '0;
        v_i            = 1'b0;
        yumi_i         = 1'b0;
        clear_model();
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_v", 128'(v_o), 128'(0));
        chk("rst_ready", 128'(ready_o), 128'(1));
        chk("rst_id", 128'(cce_id_o), 128'(0));
        chk("rst_class", 128'(class_o), 128'(0));
        chk("rst_err", 128'(err_o), 128'(0));
        chk("rst_stats", stats_o, 128'(0));
        reset_i = 1'b0;
        @(negedge clk_i);

        // Block striping (reset default): bits [7:6] of 0xC0 -> 3.
        drive_req("blk", 40'h00_8000_00C0, 2'd2, 1'b0, 6'd3);
        pop_chk("blk");

        // Page striping: bits [13:12] of 0x2000 -> 2.
        cfg(2'd1, 6'd0);
        drive_req("page", 40'h00_8000_2000, 2'd2, 1'b0, 6'd2);
        pop_chk("page");

        // Switch to hash on the same cycle as a request: that request uses page (id 0),
        // the next one uses hash: bits[7:6]=3 xor bit31 (chunk bit 1) -> 1.
        cfg_v_i    = 1'b1;
        cfg_mode_i = 2'd2;
        drive_req("cfg_same", 40'h00_8000_00C0, 2'd2, 1'b0, 6'd0);
        cfg_v_i = 1'b0;
        clear_model();
        pop_chk("cfg_same");
        drive_req("hash", 40'h00_8000_00C0, 2'd2, 1'b0, 6'd1);
        pop_chk("hash");

        // Fixed mode.
        cfg(2'd3, 6'd5);
        drive_req("fixed", 40'h00_8000_00C0, 2'd2, 1'b0, 6'd5);
        pop_chk("fixed");

        drive_req("io_did", 40'h20_0000_0000, 2'd0, 1'b0, 6'd4);
        pop_chk("io_did");
        drive_req("local", 40'h00_0040_0000, 2'd1, 1'b0, 6'd1);
        pop_chk("local");
        drive_req("io_cce", 40'h00_0140_0000, 2'd0, 1'b0, 6'd4);
        pop_chk("io_cce");
        drive_req("io_host", 40'h00_0044_0000, 2'd0, 1'b0, 6'd4);
        pop_chk("io_host");
        drive_req("coproc", 40'h10_0000_0000, 2'd3, 1'b1, 6'd0);
        pop_chk("coproc");
        drive_req("dram_top", 40'h0F_FFFF_FFC0, 2'd2, 1'b0, 6'd5);
        pop_chk("dram_top");

        // Back-to-back with yumi low: two accepts fill the buffer.
        drive_req("bp_a", 40'h20_0000_0000, 2'd0, 1'b0, 6'd4);
        drive_req("bp_b", 40'h00_0040_0000, 2'd1, 1'b0, 6'd1);
        chk("bp_full_ready", 128'(ready_o), 128'(0));
        v_i     = 1'b1;
        paddr_i = 40'h00_8000_00C0;
        pop_chk("bp_a");
        // No ready-through: the third request is taken only now.
        chk("bp_ready_after_yumi", 128'(ready_o), 128'(1));
        sb.push_back('{cls: 2'd2, err: 1'b0, id: 6'd5});
        cnt[2]++;
        @(negedge clk_i);
        v_i = 1'b0;
        pop_chk("bp_b");
        pop_chk("bp_c");
        chk("bp_drained_v", 128'(v_o), 128'(0));
        chk_stats("stats_mid");

        // Reset with two entries buffered.
        drive_req("rx", 40'h00_0040_0000, 2'd1, 1'b0, 6'd1);
        drive_req("ry", 40'h10_0000_0000, 2'd3, 1'b1, 6'd0);
        chk("pre_rst_v", 128'(v_o), 128'(1));
        #2;
        reset_i = 1'b1;
        #1;
        chk("mid_rst_v", 128'(v_o), 128'(0));
        chk("mid_rst_ready", 128'(ready_o), 128'(1));
        chk("mid_rst_class", 128'(class_o), 128'(0));
        sb.delete();
        clear_model();
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_v", 128'(v_o), 128'(0));
        drive_req("post_rst_blk", 40'h00_8000_00C0, 2'd2, 1'b0, 6'd3);
        pop_chk("post_rst_blk");
        chk_stats("stats_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_me_addr_to_cce_id_router.md
Name: bp_me_addr_to_cce_id_router

Overview:
- Pipelined, flow-controlled successor to the combinational address-to-CCE mapper.
- Accepts a stream of physical addresses and classifies each as IO, local, DRAM or coprocessor.
- Computes the destination CCE id using a runtime-selectable DRAM striping mode, then delivers the result in order through a 2-entry output buffer.
- Sits between the LCE miss path and the ME network injection logic.

Parameters:
- paddr_width_p, 40, physical address width
- cce_id_width_p, 6, output CCE id width
- num_core_p, 4, number of core CCEs; must be a power of two, >=1
- num_io_p, 1, number of IO CCEs
- io_cce_base_p, 4, id of the first IO CCE
- did_width_p, 3, domain id field width, located at paddr[paddr_width_p-1 -: did_width_p]
- block_offset_p, 6, log2 of cache block bytes
- page_offset_p, 12, log2 of page bytes
- dram_base_p, 40'h00_8000_0000, start of DRAM
- coproc_base_p, 40'h10_0000_0000, start of coprocessor space (end of DRAM)
- host_dev_p, 1, device code of the host

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- cfg_v_i  in  1  config write strobe
- cfg_mode_i  in  2  DRAM stripe mode: 0 block, 1 page, 2 xor-hash, 3 fixed
- cfg_fixed_id_i  in  cce_id_width_p  target CCE id when mode is fixed
- paddr_i  in  paddr_width_p  request address
- v_i  in  1  request valid
- ready_o  out  1  request accepted when v_i & ready_o
- cce_id_o  out  cce_id_width_p  destination CCE
- class_o  out  2  0 io, 1 local, 2 dram, 3 coproc
- err_o  out  1  unroutable (coprocessor) request
- v_o  out  1  result valid
- yumi_i  in  1  result consumed; only legal while v_o is high
- stats_o  out  128  four 32-bit per-class counters; {coproc,dram,local,io}

Behaviour:
- Reset (async, reset_i=1):
  - Buffer emptied: v_o=0, ready_o=1.
  - cce_id_o, class_o and err_o read 0.
  - Mode register set to block; fixed-id register cleared; stats_o cleared.
- Config:
  - On cfg_v_i, mode and fixed-id registers update at the clock edge.
  - The new values apply to requests accepted on later cycles.
  - A request accepted in the same cycle as cfg_v_i uses the old values.
  - Buffered results are never recomputed.
- Classification is combinational on paddr_i and latched at accept. Priority order:
  - IO: did>0, or (paddr<dram_base_p and dev==host_dev_p), or (paddr<dram_base_p and local cce>=num_core_p).
    - id = io_cce_base_p + paddr[page_offset_p +: clog2(num_io_p)].
    - When num_io_p==1, id = io_cce_base_p.
  - Local: paddr<dram_base_p. dev field = paddr[21:18]; cce field = paddr[28:22]. id = cce field.
  - DRAM: dram_base_p<=paddr<coproc_base_p. With L=clog2(num_core_p):
    - block mode: id = paddr[block_offset_p +: L]
    - page mode: id = paddr[page_offset_p +: L]
    - hash mode: id = XOR of all L-bit chunks of paddr[paddr_width_p-did_width_p-1:block_offset_p]; the top chunk is zero-padded.
    - fixed mode: id = cfg_fixed_id_i register value.
    - num_core_p==1 yields id 0 in every mode except fixed.
  - Coproc: everything else. id = 0, err_o = 1.
  - All ids are zero-extended to cce_id_width_p.
- Buffer:
  - 2-entry in-order FIFO.
  - Latency: result visible on v_o the cycle after accept.
  - ready_o = not full.
  - Enqueue and dequeue in the same cycle are both performed when not full, and occupancy is unchanged.
  - When full, ready_o=0; a yumi_i in that cycle frees an entry and ready_o=1 next cycle. There is no combinational ready-through.
  - Outputs are driven from the head entry and held stable until yumi_i.
- Reset mid-operation discards buffered entries without producing output.

Optional Feature:
- BP_ME_ADDR_ROUTE_STATS_EN defined:
  - Four 32-bit counters, each incremented at accept for the latched class.
  - Counters wrap from 2^32-1 to 0.
  - Counters are cleared by reset and by cfg_v_i.
- Not defined: counters absent and stats_o tied to 0.

Decomposition:
- Shared package bp_me_route_pkg holds:
  - bp_me_route_class_e (io/local/dram/coproc)
  - bp_me_stripe_mode_e (block/page/hash/fixed)
  - local address field positions (dev lsb 18 width 4, cce lsb 22 width 7)
- One natural sub-module: bp_me_addr_route_classify, which is purely combinational and produces {class, id, err} from paddr plus the mode registers.
- Buffer uses the existing two-entry fifo primitive.

Test Plan:
- Reset, mode left at block; paddr 40'h00_8000_00C0 -> next cycle v_o=1, class_o=2, cce_id_o=3, err_o=0.
- cfg_mode_i=1 written; paddr 40'h00_8000_2000 -> cce_id_o=2.
- cfg_mode_i=3 with fixed id 5 -> cce_id_o=5.
- paddr 40'h20_0000_0000 (did=1) -> class_o=0, cce_id_o=4.
- paddr 40'h00_0040_0000 -> class_o=1, cce_id_o=1.
- paddr 40'h00_0140_0000 (cce field 5 >= 4) -> class_o=0, cce_id_o=4.
- paddr 40'h10_0000_0000 -> class_o=3, err_o=1, cce_id_o=0.
- yumi_i held low, 3 back-to-back requests -> ready_o low after 2 accepts. Pulse yumi_i -> third request accepted the following cycle, output order preserved.
- reset_i asserted mid-stream with 2 entries buffered -> v_o=0 immediately and mode reads block afterwards.
- With the stats macro defined, after the sequence above: stats_o io/local/dram/coproc counts match the requests accepted.
